// File: rtl/alu_unit.sv
// alu_unit: 32-bit integer ALU with registered result and zero flag.
// One cycle of latency; asynchronous active-high reset.
module alu_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_1,
  input  logic [WIDTH-1:0] in_2,
  input  logic [3:0]       alu_ctrl,
  output logic [WIDTH-1:0] alu_out,
  output logic             zero
);

  localparam int SW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SLL  = 4'd2;
  localparam logic [3:0] OP_SRL  = 4'd3;
  localparam logic [3:0] OP_SRA  = 4'd4;
  localparam logic [3:0] OP_AND  = 4'd5;
  localparam logic [3:0] OP_OR   = 4'd6;
  localparam logic [3:0] OP_XOR  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;
  localparam logic [3:0] OP_PASS = 4'd10;

  logic [SW-1:0]    shamt;
  logic [WIDTH-1:0] r;
  logic             lt_s;
  logic             lt_u;

  assign shamt = in_2[SW-1:0];
  assign lt_s  = $signed(in_1) < $signed(in_2);
  assign lt_u  = in_1 < in_2;

  // Select the next result; reserved codes give 0.
  always_comb begin
    r = '0;
    case (alu_ctrl)
      OP_ADD:  r = in_1 + in_2;
      OP_SUB:  r = in_1 - in_2;
      OP_SLL:  r = in_1 << shamt;
      OP_SRL:  r = in_1 >> shamt;
      OP_SRA:  r = $signed(in_1) >>> shamt;
      OP_AND:  r = in_1 & in_2;
      OP_OR:   r = in_1 | in_2;
      OP_XOR:  r = in_1 ^ in_2;
      OP_SLT:  r = {{(WIDTH-1){1'b0}}, lt_s};
      OP_SLTU: r = {{(WIDTH-1){1'b0}}, lt_u};
      OP_PASS: r = in_2;
      default: r = '0;
    endcase
  end

  // Register result and zero flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_out <= '0;
      zero    <= 1'b1;
    end else begin
      alu_out <= r;
      zero    <= (r == '0);
    end
  end

endmodule

// File: tb/tb_alu_unit.sv
// tb_alu_unit: directed-vector bench for alu_unit.
// Inputs change on the falling edge; outputs are sampled 1ns after the rising edge.
module tb_alu_unit;

  logic        clk;
  logic        rst;
  logic [31:0] in_1;
  logic [31:0] in_2;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_out;
  logic        zero;

  int n_checks;
  int n_fail;

  alu_unit #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_1     (in_1),
    .in_2     (in_2),
    .alu_ctrl (alu_ctrl),
    .alu_out  (alu_out),
    .zero     (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic op(input string tag,
                    input logic [3:0] c,
                    input logic [31:0] a,
                    input logic [31:0] b,
                    input logic [31:0] exp,
                    input logic ez);
    @(negedge clk);
    alu_ctrl = c;
    in_1     = a;
    in_2     = b;
    @(posedge clk);
    #1;
    check({tag, ".out"}, alu_out, exp);
    check({tag, ".z"}, {31'd0, zero}, {31'd0, ez});
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    alu_ctrl = 4'd0;
    in_1     = 32'hDEAD_BEEF;
    in_2     = 32'h1234_5678;
    #1;
    check("rst_async.out", alu_out, 32'd0);
    check("rst_async.z", {31'd0, zero}, 32'd1);
    @(posedge clk);
    #1;
    check("rst_hold.out", alu_out, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    op("add",    4'd0, 32'd1, 32'd2, 32'd3, 1'b0);
    op("sub",    4'd1, 32'd2, 32'd1, 32'd1, 1'b0);
    op("sub_eq", 4'd1, 32'd1, 32'd1, 32'd0, 1'b1);
    op("sub_wr", 4'd1, 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b0);
    op("add_ov", 4'd0, 32'hFFFF_FFFF, 32'd2, 32'd1, 1'b0);
    op("sll",    4'd2, 32'd2, 32'd3, 32'h0000_0010, 1'b0);
    op("srl",    4'd3, 32'hFFFF_FFFB, 32'd1, 32'h7FFF_FFFD, 1'b0);
    op("sra",    4'd4, 32'hFFFF_FFFB, 32'd1, 32'hFFFF_FFFD, 1'b0);
    op("sra31n", 4'd4, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 1'b0);
    op("sra31p", 4'd4, 32'h7FFF_FFFF, 32'd31, 32'd0, 1'b1);
    op("srl31",  4'd3, 32'h8000_0000, 32'd31, 32'd1, 1'b0);
    op("sll_hi", 4'd2, 32'h0000_0005, 32'h0000_0021, 32'h0000_000A, 1'b0);
    op("sh0",    4'd4, 32'h8765_4321, 32'hFFFF_FFE0, 32'h8765_4321, 1'b0);
    op("and",    4'd5, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0);
    op("or",     4'd6, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1'b0);
    op("xor",    4'd7, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0);
    op("slt",    4'd8, 32'h8000_0000, 32'h7FFF_FFFF, 32'd1, 1'b0);
    op("sltu",   4'd9, 32'h8000_0000, 32'h7FFF_FFFF, 32'd0, 1'b1);
    op("sltu_t", 4'd9, 32'h7FFF_FFFF, 32'h8000_0000, 32'd1, 1'b0);
    op("slt_eq", 4'd8, 32'd5, 32'd5, 32'd0, 1'b1);
    op("pass_b", 4'd10, 32'hFFFF_FFFF, 32'h1234_5000, 32'h1234_5000, 1'b0);
    op("rsv11",  4'd11, 32'd7, 32'd9, 32'd0, 1'b1);
    op("rsv12",  4'd12, 32'd7, 32'd9, 32'd0, 1'b1);
    op("rsv15",  4'd15, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1);

    // Inputs changed between edges must not reach the outputs.
    op("pre_hold", 4'd0, 32'd10, 32'd20, 32'd30, 1'b0);
    @(negedge clk);
    alu_ctrl = 4'd1;
    in_1     = 32'd4;
    in_2     = 32'd4;
    #2;
    check("hold.out", alu_out, 32'd30);
    check("hold.z", {31'd0, zero}, 32'd0);
    @(posedge clk);
    #1;
    check("hold_upd.out", alu_out, 32'd0);
    check("hold_upd.z", {31'd0, zero}, 32'd1);

    // Mid-cycle reset clears immediately; release registers live inputs.
    op("pre_rst", 4'd6, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid.out", alu_out, 32'd0);
    check("rst_mid.z", {31'd0, zero}, 32'd1);
    @(negedge clk);
    rst      = 1'b0;
    alu_ctrl = 4'd0;
    in_1     = 32'd1;
    in_2     = 32'd2;
    @(posedge clk);
    #1;
    check("rst_rel.out", alu_out, 32'd3);
    check("rst_rel.z", {31'd0, zero}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_unit.md
Name: alu_unit

Overview:
- 32-bit integer ALU for the single-cycle processor datapath. It sits between the register-file/immediate mux and the writeback/branch logic.
- Computes arithmetic, logic, shift and compare results selected by a 4-bit control code from the ALU control decoder.
- Result and zero flag are registered: one clock of latency, asynchronous active-high reset.

Parameters:
- WIDTH, 32, datapath width of operands and result (shift amount uses the low log2(WIDTH) = 5 bits).

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-high reset
- in_1  input  WIDTH  operand A (rs1 value)
- in_2  input  WIDTH  operand B (rs2 value or immediate); also the shift amount source
- alu_ctrl  input  4  operation select
- alu_out  output  WIDTH  registered result
- zero  output  1  registered flag, 1 when the result is all zeros

Behaviour:
- Reset: while rst=1, alu_out=0 and zero=1, with immediate (asynchronous) effect. Reset is released synchronously to the next clk edge.
  - zero=1 is consistent with a zero result.
- Combinational result r is computed from the current in_1, in_2 and alu_ctrl. On each rising clk edge with rst=0: alu_out <= r and zero <= (r == 0). Latency is exactly 1 cycle, with no enable and no stall.
- Operations, by alu_ctrl:
  - 0 ADD: in_1 + in_2, modulo 2^32, carry discarded.
  - 1 SUB: in_1 - in_2, modulo 2^32. Used for equality compare: equal operands give zero=1.
  - 2 SLL: in_1 << in_2[4:0], zero fill.
  - 3 SRL: in_1 >> in_2[4:0], zero fill.
  - 4 SRA: in_1 >>> in_2[4:0], sign fill from in_1[31].
  - 5 AND: in_1 & in_2.
  - 6 OR: in_1 | in_2.
  - 7 XOR: in_1 ^ in_2.
  - 8 SLT: 1 if in_1 < in_2 as signed two's complement, else 0 (zero-extended to 32 bits).
  - 9 SLTU: 1 if in_1 < in_2 unsigned, else 0.
  - 10 PASS_B: in_2 (used for LUI-style immediates).
  - 11-15: result 0, so zero=1. These codes are reserved; no error is signalled.
- Shift boundaries:
  - in_2[31:5] are ignored.
  - A shift amount of 0 returns in_1 unchanged.
  - A shift amount of 31 is fully supported. SRA by 31 gives all ones for negative in_1 and 0 for non-negative in_1.
- Overflow: ADD/SUB overflow wraps silently; there is no overflow output.
- SLT at the extremes: 0x80000000 < 0x7FFFFFFF yields 1. SLTU of the same operands yields 0.
- X/undefined inputs need not be handled specially.
- Changing inputs between edges has no effect on the outputs until the next edge.
- Asserting rst mid-operation clears the outputs immediately. The first edge after rst deasserts registers the current inputs.

Test Plan:
- Reset: assert rst with arbitrary inputs -> alu_out=0, zero=1 immediately without a clock. Deassert rst, then ADD 1+2 -> after 1 edge alu_out=3, zero=0.
- Add/sub/compare, one edge per line:
  - ADD in_1=1, in_2=2 -> alu_out=3, zero=0.
  - SUB 2-1 -> alu_out=1, zero=0.
  - SUB 1-1 -> alu_out=0, zero=1.
  - SUB 0-1 -> 0xFFFFFFFF.
- Shifts:
  - SLL 2<<3 -> 0x00000010.
  - SRL in_1=0xFFFFFFFB, in_2=1 -> 0x7FFFFFFD.
  - SRA same operands -> 0xFFFFFFFD.
  - SRA 0x80000000 by 31 -> 0xFFFFFFFF.
  - SLL with in_2=0x00000021 -> shift by 1.
- Logic and compares:
  - AND/OR/XOR of 0xF0F0F0F0 and 0xFF00FF00 -> 0xF000F000, 0xFFF0FFF0, 0x0FF00FF0.
  - SLT 0x80000000 vs 0x7FFFFFFF -> 1.
  - SLTU same operands -> 0.
  - SLT 5 vs 5 -> 0, zero=1.
- Latency and reserved codes:
  - Change inputs mid-cycle -> outputs hold until the next rising edge.
  - alu_ctrl=12 -> alu_out=0, zero=1.
  - PASS_B in_2=0x12345000 -> 0x12345000.
